fm_tune_controller: RTL
=======================

# fm_tune_controller

Tuning sequencer for the FM demodulator's centre-frequency control word (`ctr_ctrl`). It accepts retune commands over a valid/ready handshake and ramps `ctr_ctrl` toward the target in bounded steps. Steps are applied only on NCO phase-wrap boundaries, so the block averager never integrates across a mid-block frequency change. After the final step it waits a programmable number of blocks before reporting lock. It sits between the host/config logic and the demodulator's `ctr_ctrl` input.

## Interface
- `STEP`, default 32'd1000: maximum change of `ctr_ctrl` per update, unsigned, must be ≥ 1.
- `SETTLE_BLOCKS`, default 4: phase wraps to wait after reaching the target (0–255).
- `RESET_CTRL`, default 32'd0: `ctr_ctrl` value loaded by reset.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `cmd_valid` input 1: a retune command is present.
- `cmd_ready` output 1: the block accepts a command this cycle.
- `cmd_target` input 32: target control word, unsigned.
- `abort` input 1: cancels a ramp or settle in progress.
- `phase_wrap` input 1: one-cycle pulse when the NCO phase accumulator overflows (block boundary).
- `ctr_ctrl` output 32: registered control word driven to the demodulator.
- `busy` output 1: high in RAMP or SETTLE.
- `locked` output 1: high once the last command (or reset) has completed settling.
- `done` output 1: one-cycle pulse when settling completes.

## Operation
States are IDLE, RAMP and SETTLE. A registered `target` and an 8-bit settle counter `scnt` hold the working values.

- **Reset:** `ctr_ctrl`=RESET_CTRL, state=SETTLE, `scnt`=SETTLE_BLOCKS, `locked`=0, `done`=0, `busy`=1, `cmd_ready`=0.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`: latch `cmd_target`, clear `locked`, go to RAMP.
  - `abort` is ignored in IDLE.
- **RAMP:** on each `phase_wrap`:
  - Compute `diff` = |target − ctr_ctrl| using unsigned 32-bit values and a 33-bit intermediate. There is no modular shortest-path logic.
  - If `diff` ≤ STEP: `ctr_ctrl` = target, `scnt` = SETTLE_BLOCKS, go to SETTLE.
  - Otherwise: `ctr_ctrl` ± STEP, moving toward target. The result never overshoots and never wraps modulo 2^32.
  - A target equal to the current value still takes one wrap: RAMP → SETTLE.
- **SETTLE:**
  - If `scnt`==0: go to IDLE on the next edge.
  - Otherwise, on each `phase_wrap` decrement `scnt`. When it reaches 0, go to IDLE.
  - On entry to IDLE from SETTLE: `locked`=1 and `done`=1 for that one cycle. This applies to both reset-initiated and command-initiated settles.
- **Abort (in RAMP or SETTLE):**
  - Next state is IDLE and `ctr_ctrl` holds its current value.
  - `locked` stays 0 and there is no `done` pulse.
  - Abort has priority over a `phase_wrap` in the same cycle; no step or decrement is applied.
- **Reset mid-operation:** unconditionally restores the reset values above. Any pending target is discarded.
- Commands presented while `cmd_ready`=0 are not accepted. The source must hold `cmd_valid` and `cmd_target` stable until accepted.

## Timing
- **Command acceptance:** a command accepted at edge N gives state=RAMP, `busy`=1, `cmd_ready`=0 and `locked`=0 from cycle N+1.
- **Step update:** a `phase_wrap` sampled high at edge M makes the new `ctr_ctrl` visible from M+1. At most one update occurs per `phase_wrap` pulse.
- **Completion:** `done`, `locked`=1 and `cmd_ready`=1 appear together in the cycle after the settling wrap.
  - A new command may be accepted in that same cycle, which clears `locked` from the next cycle.
- **Total latency:** ⌈|Δ|/STEP⌉ wraps (minimum 1) plus SETTLE_BLOCKS wraps, plus 1 cycle.
  - With SETTLE_BLOCKS=0: one extra cycle in SETTLE with no wrap needed.
- **Output registration:** all outputs are registered. `cmd_ready` is a state decode (IDLE), with no combinational path from `cmd_valid`.

## Test plan
Parameters for tests 1–5: STEP=1000, SETTLE_BLOCKS=2, RESET_CTRL=5000.

1. **Reset:** assert reset 3 cycles, release, then pulse `phase_wrap` twice. Required: `ctr_ctrl`=5000 throughout; `locked`=0 and `cmd_ready`=0 until the cycle after the 2nd wrap; then `done` pulses once, `locked`=1, `cmd_ready`=1.
2. **Up-ramp:** send `cmd_target`=7500 and issue wraps. Required: `ctr_ctrl` goes 6000 → 7000 → 7500 on wraps 1–3; `done` one cycle after wrap 5; `busy` high from acceptance until `done`.
3. **Down-ramp and no-op:**
   - From 7500, target 7000. Required: one wrap gives 7000, then 2 settle wraps, then `done`.
   - Then target 7000 again. Required: RAMP → SETTLE on the first wrap with `ctr_ctrl` unchanged, and `done` after 2 more wraps.
4. **Abort mid-ramp:** from 5000, target 9000; after the wrap yielding 6000, assert `abort` together with `phase_wrap`. Required: `ctr_ctrl` stays 6000, IDLE next cycle, `locked`=0, no `done`, `cmd_ready`=1.
5. **Reset mid-settle:** assert reset during SETTLE at `ctr_ctrl`=7500. Required: next cycle `ctr_ctrl`=5000, state=SETTLE, `scnt`=2, `locked`=0.
6. **Full-range unsigned arithmetic:** STEP=32'h8000_0000, `ctr_ctrl`=32'h0000_0100, target 32'hFFFF_FF00. Required: wrap 1 gives 32'h8000_0100 (upward, no modular wrap); wrap 2 gives 32'hFFFF_FF00 and enters SETTLE.

Source files
------------

// File: rtl/fm_tune_controller.sv
// Tuning sequencer for the FM demodulator centre-frequency word.
// Accepts retune commands, ramps ctr_ctrl toward the target in steps of at
// most STEP, applied only on NCO phase-wrap boundaries, then waits
// SETTLE_BLOCKS wraps before reporting lock.
module fm_tune_controller #(
  parameter logic [31:0] STEP          = 32'd1000,
  parameter int unsigned SETTLE_BLOCKS = 4,
  parameter logic [31:0] RESET_CTRL    = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_target,
  input  logic        abort,
  input  logic        phase_wrap,
  output logic [31:0] ctr_ctrl,
  output logic        busy,
  output logic        locked,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_SETTLE
  } state_t;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_BLOCKS);

  state_t      state_q, state_d;
  logic [31:0] ctr_q, ctr_d;
  logic [31:0] target_q, target_d;
  logic [7:0]  scnt_q, scnt_d;
  logic        locked_q, locked_d;
  logic        done_q, done_d;

  // Signed distance to target; bit 32 set means the target lies below ctr.
  logic [32:0] delta;
  logic        move_down;
  logic [31:0] diff;

  // Magnitude of the remaining distance using plain unsigned arithmetic.
  always_comb begin
    delta     = {1'b0, target_q} - {1'b0, ctr_q};
    move_down = delta[32];
    diff      = move_down ? (~delta[31:0] + 32'd1) : delta[31:0];
  end

  // Next-state and next-output logic for the IDLE/RAMP/SETTLE sequencer.
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    target_d = target_q;
    scnt_d   = scnt_q;
    locked_d = locked_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // abort has no effect here; only a command moves us out.
        if (cmd_valid) begin
          target_d = cmd_target;
          locked_d = 1'b0;
          state_d  = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (abort) begin
          // Hold the current word; lock is not reported for an aborted ramp.
          state_d = ST_IDLE;
        end else if (phase_wrap) begin
          if (diff <= STEP) begin
            ctr_d   = target_q;
            scnt_d  = SETTLE_INIT;
            state_d = ST_SETTLE;
          end else if (move_down) begin
            // diff > STEP guarantees no underflow and no overshoot.
            ctr_d = ctr_q - STEP;
          end else begin
            // diff > STEP guarantees no overflow and no overshoot.
            ctr_d = ctr_q + STEP;
          end
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (scnt_q == 8'd0) begin
          state_d  = ST_IDLE;
          locked_d = 1'b1;
          done_d   = 1'b1;
        end else if (phase_wrap) begin
          scnt_d = scnt_q - 8'd1;
          if (scnt_q == 8'd1) begin
            state_d  = ST_IDLE;
            locked_d = 1'b1;
            done_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset starts a settle at RESET_CTRL.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_SETTLE;
      ctr_q    <= RESET_CTRL;
      target_q <= RESET_CTRL;
      scnt_q   <= SETTLE_INIT;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      target_q <= target_d;
      scnt_q   <= scnt_d;
      locked_q <= locked_d;
      done_q   <= done_d;
    end
  end

  assign ctr_ctrl  = ctr_q;
  assign locked    = locked_q;
  assign done      = done_q;
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

endmodule
